// File: rtl/systolic_pkg.sv
// Shared types, constants and packing helpers for the systolic feeder.
package systolic_pkg;

  localparam int unsigned SYS_N         = 3;
  localparam int unsigned SYS_DATA_SIZE = 8;
  localparam int unsigned STREAM_LEN    = 3 * SYS_N - 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  // LSB of element [r][c] in a row-major packed NxN matrix of w-bit elements.
  function automatic int unsigned elem_lsb(input int unsigned r, input int unsigned c,
                                           input int unsigned n, input int unsigned w);
    return (r * n + c) * w;
  endfunction

  // LSB of lane `lane` in a packed bus of w-bit lanes.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned w);
    return lane * w;
  endfunction

endpackage

// File: rtl/skew_lane_sel.sv
// Picks the diagonally skewed matrix element for one lane at stream time t.
// Row lane i (TRANSPOSE=0) yields M[i][t-i]; column lane j (TRANSPOSE=1) yields M[t-j][j].
module skew_lane_sel
  import systolic_pkg::*;
#(
  parameter int unsigned N         = SYS_N,
  parameter int unsigned W         = SYS_DATA_SIZE,
  parameter int unsigned CNT_W     = 3,
  parameter int unsigned LANE      = 0,
  parameter bit          TRANSPOSE = 1'b0
) (
  input  logic [N*N*W-1:0] i_mat,
  input  logic [CNT_W-1:0] i_t,
  output logic [W-1:0]     o_elem_c
);

  int unsigned w_t;
  int unsigned w_k;
  int unsigned w_row;
  int unsigned w_col;

  // Element is live only while the skewed index t-LANE lies inside 0..N-1.
  always_comb begin
    o_elem_c = '0;
    w_t      = 32'(i_t);
    w_k      = 0;
    w_row    = 0;
    w_col    = 0;
    if ((w_t >= LANE) && ((w_t - LANE) < N)) begin
      w_k      = w_t - LANE;
      w_row    = TRANSPOSE ? w_k : LANE;
      w_col    = TRANSPOSE ? LANE : w_k;
      o_elem_c = i_mat[elem_lsb(w_row, w_col, N, W) +: W];
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Feeds an NxN output-stationary systolic array: clear, skewed stream, done pulse.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned N         = SYS_N,
  parameter int unsigned data_size = SYS_DATA_SIZE,
  parameter int unsigned CNT_W     = $clog2(3 * N - 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [N*N*data_size-1:0]   mat_a,
  input  logic [N*N*data_size-1:0]   mat_b,
  output logic                       ready,
  output logic                       arr_reset,
  output logic [N*data_size-1:0]     a_arr,
  output logic [N*data_size-1:0]     b_arr,
  output logic                       done
);

  localparam int unsigned STREAM_LAST = 3 * N - 3;

  state_t                     r_state;
  logic [CNT_W-1:0]           r_cnt;
  logic [N*N*data_size-1:0]   r_mat_a;
  logic [N*N*data_size-1:0]   r_mat_b;
  logic [N*data_size-1:0]     r_a_arr;
  logic [N*data_size-1:0]     r_b_arr;
  logic                       r_ready;
  logic                       r_arr_reset;
  logic                       r_done;

  logic [CNT_W-1:0]           w_t_next;
  logic [N*data_size-1:0]     w_a_next;
  logic [N*data_size-1:0]     w_b_next;

  // Stream time of the cycle being registered: 0 on leaving CLEAR, cnt+1 inside STREAM.
  assign w_t_next = (r_state == STREAM) ? (r_cnt + CNT_W'(1)) : '0;

  for (genvar g = 0; g < N; g++) begin : g_lane
    skew_lane_sel #(
      .N(N), .W(data_size), .CNT_W(CNT_W), .LANE(g), .TRANSPOSE(1'b0)
    ) u_row_sel (
      .i_mat    (r_mat_a),
      .i_t      (w_t_next),
      .o_elem_c (w_a_next[lane_lsb(g, data_size) +: data_size])
    );
    skew_lane_sel #(
      .N(N), .W(data_size), .CNT_W(CNT_W), .LANE(g), .TRANSPOSE(1'b1)
    ) u_col_sel (
      .i_mat    (r_mat_b),
      .i_t      (w_t_next),
      .o_elem_c (w_b_next[lane_lsb(g, data_size) +: data_size])
    );
  end

  // Job sequencer with registered outputs; reset discards any job in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_mat_a     <= '0;
      r_mat_b     <= '0;
      r_a_arr     <= '0;
      r_b_arr     <= '0;
      r_ready     <= 1'b0;
      r_arr_reset <= 1'b1;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt       <= '0;
          r_a_arr     <= '0;
          r_b_arr     <= '0;
          r_done      <= 1'b0;
          r_ready     <= 1'b1;
          r_arr_reset <= 1'b0;
          if (start && r_ready) begin
            r_mat_a     <= mat_a;
            r_mat_b     <= mat_b;
            r_ready     <= 1'b0;
            r_arr_reset <= 1'b1;
            r_state     <= CLEAR;
          end
        end
        CLEAR: begin
          r_cnt       <= '0;
          r_arr_reset <= 1'b0;
          r_a_arr     <= w_a_next;
          r_b_arr     <= w_b_next;
          r_state     <= STREAM;
        end
        STREAM: begin
          if (r_cnt == CNT_W'(STREAM_LAST)) begin
            r_a_arr <= '0;
            r_b_arr <= '0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_a_arr <= w_a_next;
            r_b_arr <= w_b_next;
          end
        end
        DONE: begin
          r_cnt   <= '0;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready     = r_ready;
  assign arr_reset = r_arr_reset;
  assign a_arr     = r_a_arr;
  assign b_arr     = r_b_arr;
  assign done      = r_done;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder with a behavioural 3x3 output-stationary array.
module tb_systolic_feeder;

  localparam int unsigned N  = 3;
  localparam int unsigned DW = 8;

  logic                  clk;
  logic                  reset;
  logic                  start;
  logic [N*N*DW-1:0]     mat_a;
  logic [N*N*DW-1:0]     mat_b;
  logic                  ready;
  logic                  arr_reset;
  logic [N*DW-1:0]       a_arr;
  logic [N*DW-1:0]       b_arr;
  logic                  done;

  int n_pass;
  int n_total;

  systolic_feeder #(.N(N), .data_size(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mat_a     (mat_a),
    .mat_b     (mat_b),
    .ready     (ready),
    .arr_reset (arr_reset),
    .a_arr     (a_arr),
    .b_arr     (b_arr),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural output-stationary array: a moves right, b moves down, acc += a*b.
  logic [DW-1:0] pa [N][N];
  logic [DW-1:0] pb [N][N];
  int            acc [N][N];
  logic [DW-1:0] ain [N][N];
  logic [DW-1:0] bin [N][N];

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      ain[i][0] = a_arr[i*DW +: DW];
      bin[0][i] = b_arr[i*DW +: DW];
      for (int j = 1; j < N; j++) begin
        ain[i][j] = pa[i][j-1];
        bin[j][i] = pb[j-1][i];
      end
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (arr_reset) begin
          pa[i][j]  <= '0;
          pb[i][j]  <= '0;
          acc[i][j] <= 0;
        end else begin
          pa[i][j]  <= ain[i][j];
          pb[i][j]  <= bin[i][j];
          acc[i][j] <= acc[i][j] + int'(ain[i][j]) * int'(bin[i][j]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*N*DW-1:0] mat_ident();
    logic [N*N*DW-1:0] m;
    m = '0;
    for (int r = 0; r < N; r++) m[(r*N+r)*DW +: DW] = 8'd1;
    return m;
  endfunction

  function automatic logic [N*N*DW-1:0] mat_seq();
    logic [N*N*DW-1:0] m;
    for (int k = 0; k < N*N; k++) m[k*DW +: DW] = 8'(k + 1);
    return m;
  endfunction

  function automatic logic [N*N*DW-1:0] mat_hex(input logic [7:0] base);
    logic [N*N*DW-1:0] m;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) m[(r*N+c)*DW +: DW] = base + 8'(16*r + c);
    return m;
  endfunction

  // Drives one accepted start; returns in cycle 1.
  task automatic launch(input logic [N*N*DW-1:0] a, input logic [N*N*DW-1:0] b);
    mat_a = a;
    mat_b = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    mat_a = '0;
    mat_b = '0;
    tick();
    tick();
    n_total++; if (ready !== 1'b0) $display("FAIL reset_ready got %b exp 0", ready); else n_pass++;
    n_total++; if (arr_reset !== 1'b1) $display("FAIL reset_arr_reset got %b exp 1", arr_reset); else n_pass++;
    n_total++; if (a_arr !== '0 || b_arr !== '0) $display("FAIL reset_buses got %h %h exp 0", a_arr, b_arr); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else n_pass++;
    reset = 1'b0;
    tick();
    n_total++; if (ready !== 1'b1) $display("FAIL idle_ready got %b exp 1", ready); else n_pass++;
    n_total++; if (arr_reset !== 1'b0) $display("FAIL idle_arr_reset got %b exp 0", arr_reset); else n_pass++;
  endtask

  task automatic test_identity();
    logic [N*N*DW-1:0] b;
    b = mat_seq();
    launch(mat_ident(), b);
    for (int c = 1; c <= 10; c++) begin
      n_total++; if (ready !== (c == 10)) $display("FAIL id_ready c%0d got %b exp %b", c, ready, c == 10); else n_pass++;
      n_total++; if (arr_reset !== (c == 1)) $display("FAIL id_arr_reset c%0d got %b exp %b", c, arr_reset, c == 1); else n_pass++;
      n_total++; if (done !== (c == 9)) $display("FAIL id_done c%0d got %b exp %b", c, done, c == 9); else n_pass++;
      if (c == 9) begin
        for (int k = 0; k < N*N; k++) begin
          n_total++;
          if (acc[k/N][k%N] !== int'(b[k*DW +: DW]))
            $display("FAIL id_C[%0d][%0d] got %0d exp %0d", k/N, k%N, acc[k/N][k%N], b[k*DW +: DW]);
          else n_pass++;
        end
      end
      if (c < 10) tick();
    end
  endtask

  task automatic test_skew();
    logic [N*DW-1:0] exp_a [1:10];
    logic [N*DW-1:0] exp_b [1:10];
    for (int c = 1; c <= 10; c++) begin exp_a[c] = '0; exp_b[c] = '0; end
    exp_b[2] = 24'h000080;
    exp_a[3] = 24'h001001; exp_b[3] = 24'h008190;
    exp_a[4] = 24'h201102; exp_b[4] = 24'h8291A0;
    exp_a[5] = 24'h211200; exp_b[5] = 24'h92A100;
    exp_a[6] = 24'h220000; exp_b[6] = 24'hA20000;
    launch(mat_hex(8'h00), mat_hex(8'h80));
    for (int c = 1; c <= 10; c++) begin
      n_total++; if (a_arr !== exp_a[c]) $display("FAIL skew_a c%0d got %h exp %h", c, a_arr, exp_a[c]); else n_pass++;
      n_total++; if (b_arr !== exp_b[c]) $display("FAIL skew_b c%0d got %h exp %h", c, b_arr, exp_b[c]); else n_pass++;
      if (c < 10) tick();
    end
  endtask

  task automatic test_back_to_back();
    int sum;
    launch(mat_ident(), mat_seq());
    start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      n_total++; if (done !== (c == 9)) $display("FAIL b2b_done c%0d got %b exp %b", c, done, c == 9); else n_pass++;
      n_total++; if (ready !== (c == 10)) $display("FAIL b2b_ready c%0d got %b exp %b", c, ready, c == 10); else n_pass++;
      n_total++; if (arr_reset !== (c == 1 || c == 11)) $display("FAIL b2b_arr_reset c%0d got %b exp %b", c, arr_reset, c == 1 || c == 11); else n_pass++;
      if (c == 12) begin
        sum = 0;
        for (int k = 0; k < N*N; k++) sum += acc[k/N][k%N];
        n_total++; if (sum !== 0) $display("FAIL b2b_cleared got %0d exp 0", sum); else n_pass++;
      end
      if (c == 12) start = 1'b0;
      tick();
    end
    // second job started at edge 10 reaches done in cycle 19
    for (int c = 13; c <= 20; c++) begin
      n_total++; if (done !== (c == 19)) $display("FAIL b2b_done2 c%0d got %b exp %b", c, done, c == 19); else n_pass++;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    launch(mat_hex(8'h00), mat_hex(8'h80));
    for (int c = 1; c < 5; c++) tick();
    n_total++; if (a_arr !== 24'h211200) $display("FAIL mid_pre_a got %h exp 211200", a_arr); else n_pass++;
    reset = 1'b1;
    tick();
    n_total++; if (a_arr !== '0 || b_arr !== '0) $display("FAIL mid_buses got %h %h exp 0", a_arr, b_arr); else n_pass++;
    n_total++; if (arr_reset !== 1'b1) $display("FAIL mid_arr_reset got %b exp 1", arr_reset); else n_pass++;
    n_total++; if (ready !== 1'b0) $display("FAIL mid_ready got %b exp 0", ready); else n_pass++;
    tick();
    n_total++; if (ready !== 1'b0) $display("FAIL mid_ready_hold got %b exp 0", ready); else n_pass++;
    reset = 1'b0;
    tick();
    n_total++; if (ready !== 1'b1) $display("FAIL mid_ready_rel got %b exp 1", ready); else n_pass++;
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      if (done === 1'b1) dones++;
      tick();
    end
    n_total++; if (dones !== 0) $display("FAIL mid_no_done got %0d exp 0", dones); else n_pass++;
  endtask

  task automatic test_saturate();
    logic [N*N*DW-1:0] m;
    for (int k = 0; k < N*N; k++) m[k*DW +: DW] = 8'h7F;
    launch(m, m);
    mat_a = '0;
    for (int c = 1; c < 9; c++) tick();
    n_total++; if (done !== 1'b1) $display("FAIL sat_done got %b exp 1", done); else n_pass++;
    for (int k = 0; k < N*N; k++) begin
      n_total++;
      if (acc[k/N][k%N] !== 48387) $display("FAIL sat_C[%0d][%0d] got %0d exp 48387", k/N, k%N, acc[k/N][k%N]);
      else n_pass++;
    end
    tick();
  endtask

  task automatic test_reset_start();
    mat_a = mat_ident();
    mat_b = mat_seq();
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    tick();
    n_total++; if (ready !== 1'b1) $display("FAIL rs_ready got %b exp 1", ready); else n_pass++;
    n_total++; if (a_arr !== '0 || b_arr !== '0) $display("FAIL rs_buses got %h %h exp 0", a_arr, b_arr); else n_pass++;
    n_total++; if (arr_reset !== 1'b0) $display("FAIL rs_arr_reset got %b exp 0", arr_reset); else n_pass++;
    tick();
    n_total++; if (ready !== 1'b1) $display("FAIL rs_no_accept got %b exp 1", ready); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL rs_done got %b exp 0", done); else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_identity();
    test_skew();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    test_reset_start();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Upstream stage of the NxN output-stationary systolic array top.
- Accepts two full NxN operand matrices A and B through a start/ready handshake.
- Clears the array's accumulators, then streams A rows into a_arr and B columns into b_arr with diagonal skew, so PE(i,j) receives A[i][k] and B[k][j] in the same cycle.
- Pulses done once every PE has accumulated all N products, at which point the array's out_arr holds C = A x B.

Parameters:
- N, 3: array dimension; matrices are NxN.
- data_size, 8: operand element width in bits; must match the array.
- CNT_W, $clog2(3*N-1): stream counter width (derived; do not override).

Ports:
- clk  input  1  single clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; accepted on a rising edge where start=1 and ready=1.
- mat_a  input  N*N*data_size  element A[r][c] at bits [(r*N+c)*data_size +: data_size].
- mat_b  input  N*N*data_size  element B[r][c], same packing as mat_a.
- ready  output  1  high only in IDLE.
- arr_reset  output  1  synchronous clear to the array's reset input.
- a_arr  output  N*data_size  row lane i at [i*data_size +: data_size]; drives array a_arr.
- b_arr  output  N*data_size  column lane j at [j*data_size +: data_size]; drives array b_arr.
- done  output  1  one-cycle pulse: array results are valid.

Behaviour:
- All outputs are registered; nothing is combinational from inputs to outputs.
- Reset values: state=IDLE, counter=0, a_arr=0, b_arr=0, done=0, arr_reset=1. arr_reset stays 1 for as long as reset is held.
- After reset deasserts, IDLE drives arr_reset=0 and ready=1.
- Handshake: at the accepting edge, mat_a and mat_b are latched into internal NxN registers.
  - Later changes on mat_a or mat_b have no effect.
  - start is ignored whenever ready=0.
- FSM: IDLE -> CLEAR -> STREAM -> DONE -> IDLE.
- Cycle numbering is relative to the accepting edge:
  - Cycle 1, CLEAR: arr_reset=1, a_arr=0, b_arr=0, ready=0.
  - Cycles 2 .. 3N-1, STREAM, stream time t = 0 .. 3N-3:
    - a_arr lane i = A[i][t-i] if 0 <= t-i <= N-1, else 0.
    - b_arr lane j = B[t-j][j] if 0 <= t-j <= N-1, else 0.
    - arr_reset=0.
  - Cycles 2N+1 .. 3N-1 are all-zero flush cycles. They propagate the last operands to PE(N-1,N-1); zero operands leave the accumulators unchanged.
  - Cycle 3N, DONE: done=1, buses 0, ready=0. Next state is IDLE.
- After done, a_arr and b_arr stay 0, so out_arr remains stable until the next CLEAR.
- Throughput: one job per 3N+1 cycles. A start is first accepted in the cycle after done.
- Counter: increments by 1 in STREAM and leaves STREAM when it equals 3N-3. It never wraps and returns to 0 in IDLE.
- Reset mid-operation returns to the reset state on the next edge. The latched matrices are discarded and any pending done is never issued.
- Reset and start in the same cycle: reset wins and start is not accepted.
- Operand values pass through unmodified; there is no arithmetic in this block. Width overflow of accumulated sums is the array's concern.

Decomposition:
- Shared package systolic_pkg holds:
  - the state typedef (IDLE, CLEAR, STREAM, DONE);
  - the localparam STREAM_LEN = 3*N-2;
  - the lane-slice helper functions (element index r*N+c).
- One sub-module, skew_lane_sel: given the latched matrix, a lane index and t, it returns the skewed element or 0.
  - It is instantiated 2N times: N row lanes and N column lanes with B transposed.
  - The top level keeps the FSM, counter and output registers.

Test Plan (N=3, data_size=8, feeder driving the systolic array top):
- A=identity, B=1..9 row-major; start at cycle 0 -> ready=0 for cycles 1..9, arr_reset=1 only in cycle 1, done=1 only in cycle 9, array out_arr C == B.
- A[r][c]=16r+c, B[r][c]=0x80+16r+c -> bus values per cycle:
  - t=0: a_arr lanes {0x00,0,0}.
  - t=2: a_arr lanes {0x02,0x11,0x20}, b_arr lanes {0xA0,0x91,0x82}.
  - t=5..6: all lanes 0.
- start held high across cycles 1..12 after the first accept -> exactly one done in cycle 9; second job accepted at cycle 10 with arr_reset=1 in cycle 11; the prior C is cleared.
- reset asserted during cycle 5 (mid-STREAM) -> next cycle a_arr=b_arr=0, arr_reset=1, ready=0 while reset is held; after release ready=1 and no done pulse is ever issued for the aborted job.
- All A,B elements 0x7F -> every C[i][j] = 48387; mat_a changed to 0 after acceptance does not alter the result.
- Reset and start in the same cycle -> no accept; ready=1 and all buses 0 once reset is released.
